// File: rtl/time_of_day_counter.sv
// time_of_day_counter: hh:mm:ss timekeeper with a 1 Hz prescaler, run/pause,
// range-checked per-field set, carry ticks and a 12/24-hour display view.
module time_of_day_counter #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       set_valid,
    input  logic [1:0] set_field,
    input  logic [5:0] set_value,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [4:0] disp_hours,
    output logic       pm,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       hour_tick,
    output logic       day_tick,
    output logic       set_ack,
    output logic       set_err
);

    localparam int PRE_W = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] prescaler;
    logic             set_in_range;
    logic             set_ok;
    logic             set_bad;

    // Classify the set request; value is checked at full width before any truncation.
    always_comb begin
        set_in_range = 1'b0;
        case (set_field)
            2'd0, 2'd1: set_in_range = (set_value <= 6'd59);
            2'd2:       set_in_range = (set_value <= 6'd23);
            default:    set_in_range = 1'b0;
        endcase
        set_ok  = set_valid && set_in_range;
        set_bad = set_valid && !set_in_range;
    end

    // Prescaler, counters, carry ticks and set handshake.
    // An accepted set takes priority over advancing, which holds the prescaler
    // for one cycle so a pending wrap simply happens on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            seconds   <= '0;
            minutes   <= '0;
            hours     <= '0;
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            set_ack   <= set_ok;
            set_err   <= set_bad;
            if (set_ok) begin
                case (set_field)
                    2'd0: begin
                        seconds   <= set_value;
                        prescaler <= '0;
                    end
                    2'd1:    minutes <= set_value;
                    2'd2:    hours   <= set_value[4:0];
                    default: ;
                endcase
            end else if (run) begin
                if (prescaler == PRE_MAX) begin
                    prescaler <= '0;
                    sec_tick  <= 1'b1;
                    if (seconds == 6'd59) begin
                        seconds  <= '0;
                        min_tick <= 1'b1;
                        if (minutes == 6'd59) begin
                            minutes   <= '0;
                            hour_tick <= 1'b1;
                            if (hours == 5'd23) begin
                                hours    <= '0;
                                day_tick <= 1'b1;
                            end else begin
                                hours <= hours + 5'd1;
                            end
                        end else begin
                            minutes <= minutes + 6'd1;
                        end
                    end else begin
                        seconds <= seconds + 6'd1;
                    end
                end else begin
                    prescaler <= prescaler + PRE_W'(1);
                end
            end
        end
    end

    // Display view of the hours register in the selected format.
    always_comb begin
        disp_hours = hours;
        pm         = 1'b0;
        if (mode_12h) begin
            pm = (hours >= 5'd12);
            if (hours == 5'd0)
                disp_hours = 5'd12;
            else if (hours > 5'd12)
                disp_hours = hours - 5'd12;
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Self-checking bench for time_of_day_counter: directed scenarios plus random
// stimulus, all checked against a seconds-of-day reference model.
module tb_time_of_day_counter;

    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_valid = 1'b0;
    logic [1:0] set_field = '0;
    logic [5:0] set_value = '0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [4:0] disp_hours;
    logic       pm;
    logic       sec_tick, min_tick, hour_tick, day_tick;
    logic       set_ack, set_err;

    time_of_day_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
        .set_valid(set_valid), .set_field(set_field), .set_value(set_value),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .disp_hours(disp_hours), .pm(pm),
        .sec_tick(sec_tick), .min_tick(min_tick), .hour_tick(hour_tick),
        .day_tick(day_tick), .set_ack(set_ack), .set_err(set_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time of day as seconds since midnight plus a cycle count.
    int tod = 0;
    int pre = 0;
    bit m_sec, m_min, m_hour, m_day, m_ack, m_err;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        tod = 0; pre = 0;
        {m_sec, m_min, m_hour, m_day, m_ack, m_err} = '0;
    endtask

    task automatic model_edge();
        int h, m, s, v;
        bit ok;
        {m_sec, m_min, m_hour, m_day, m_ack, m_err} = '0;
        v  = int'(set_value);
        ok = set_valid && ((set_field <= 2'd1 && v < 60) || (set_field == 2'd2 && v < 24));
        if (set_valid && !ok) m_err = 1'b1;
        if (ok) begin
            m_ack = 1'b1;
            h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
            if (set_field == 2'd0) begin s = v; pre = 0; end
            else if (set_field == 2'd1) m = v;
            else h = v;
            tod = h * 3600 + m * 60 + s;
        end else if (run) begin
            if (pre == CLK_HZ - 1) begin
                pre    = 0;
                tod    = (tod + 1) % 86400;
                m_sec  = 1'b1;
                m_min  = (tod % 60 == 0);
                m_hour = (tod % 3600 == 0);
                m_day  = (tod == 0);
            end else begin
                pre++;
            end
        end
    endtask

    task automatic check_all();
        int h, dh;
        h  = tod / 3600;
        dh = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
        check("seconds", seconds, tod % 60);
        check("minutes", minutes, (tod / 60) % 60);
        check("hours", hours, h);
        check("disp_hours", disp_hours, dh);
        check("pm", pm, (mode_12h && h >= 12) ? 1 : 0);
        check("sec_tick", sec_tick, m_sec);
        check("min_tick", min_tick, m_min);
        check("hour_tick", hour_tick, m_hour);
        check("day_tick", day_tick, m_day);
        check("set_ack", set_ack, m_ack);
        check("set_err", set_err, m_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_set(input logic [1:0] f, input logic [5:0] v);
        set_valid = 1'b1; set_field = f; set_value = v;
        step();
        set_valid = 1'b0;
    endtask

    initial begin
        int ticks, acks, errs, prev_sec, n;
        int hr_tab[5];
        int dh_tab[5];
        int pm_tab[5];
        hr_tab = '{0, 11, 12, 13, 23};
        dh_tab = '{12, 11, 12, 1, 11};
        pm_tab = '{0, 0, 1, 1, 1};

        // 1. reset mid-count, then 8 running cycles
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 6; i++) step();
        do_reset();
        ticks = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (sec_tick) ticks++;
            check("t1_tick_cycle", sec_tick, (i == 4 || i == 8) ? 1 : 0);
        end
        check("t1_ticks", ticks, 2);
        check("t1_seconds", seconds, 2);

        // 2. full-day rollover
        run = 1'b0;
        do_set(2'd2, 6'd23);
        do_set(2'd1, 6'd59);
        do_set(2'd0, 6'd59);
        run = 1'b1;
        n = 0;
        while (!sec_tick && n < 10) begin step(); n++; end
        check("t2_latency", n, 4);
        check("t2_all_zero", {hours, minutes, seconds}, 0);
        check("t2_ticks", {sec_tick, min_tick, hour_tick, day_tick}, 4'hF);

        // 3. rejected sets
        run = 1'b0;
        do_set(2'd1, 6'd17);
        do_set(2'd2, 6'd5);
        acks = 0; errs = 0;
        do_set(2'd1, 6'd60); acks += set_ack; errs += set_err;
        do_set(2'd2, 6'd24); acks += set_ack; errs += set_err;
        do_set(2'd3, 6'd5);  acks += set_ack; errs += set_err;
        do_set(2'd0, 6'd63); acks += set_ack; errs += set_err;
        check("t3_errs", errs, 4);
        check("t3_acks", acks, 0);
        check("t3_minutes", minutes, 17);
        check("t3_hours", hours, 5);

        // 4. accepted set while the prescaler is about to wrap
        run = 1'b1;
        n = 0;
        while (pre != CLK_HZ - 1 && n < 10) begin step(); n++; end
        check("t4_reach_wrap", (pre == CLK_HZ - 1) ? 1 : 0, 1);
        prev_sec = seconds;
        do_set(2'd1, 6'd42);
        check("t4_no_tick_on_set", sec_tick, 0);
        step();
        check("t4_deferred_tick", sec_tick, 1);
        check("t4_seconds", seconds, (prev_sec + 1) % 60);

        // 5. 12-hour display
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mode_12h = 1'b0;
            do_set(2'd2, 6'(hr_tab[i]));
            mode_12h = 1'b1;
            #1;
            check("t5_disp", disp_hours, dh_tab[i]);
            check("t5_pm", pm, pm_tab[i]);
            mode_12h = 1'b0;
            #1;
            check("t5_disp24", disp_hours, hr_tab[i]);
            check("t5_pm24", pm, 0);
        end

        // 6. paused, then set seconds and resume
        run = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            ticks += sec_tick + min_tick + hour_tick + day_tick;
        end
        check("t6_no_ticks", ticks, 0);
        do_set(2'd0, 6'd30);
        check("t6_ack", set_ack, 1);
        check("t6_sec30", seconds, 30);
        run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("t6_tick_cycle", sec_tick, (i == 4) ? 1 : 0);
        end
        check("t6_sec31", seconds, 31);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            run       = ($urandom_range(0, 9) != 0);
            mode_12h  = $urandom_range(0, 1);
            set_valid = ($urandom_range(0, 9) == 0);
            set_field = 2'($urandom_range(0, 3));
            set_value = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                      : 6'($urandom_range(55, 59));
            step();
            check("ack_err_exclusive", set_ack & set_err, 0);
        end
        set_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
